// File: rtl/tmc_spi_pkg.sv
// Shared constants and state encoding for the 40-bit stepper-driver SPI responder.
package tmc_spi_pkg;

  localparam int unsigned FRAME_BITS     = 40;
  localparam int unsigned ADDR_BITS      = 7;
  localparam int unsigned DATA_BITS      = 32;
  localparam int unsigned WRITE_FLAG_BIT = 39;
  localparam int unsigned CNT_BITS       = 6;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT,
    COMMIT
  } state_e;

endpackage

// File: rtl/tmc_spi_responder_sync_edge.sv
// Two-flop synchroniser with registered one-cycle rise/fall pulses.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_rise;
  logic r_fall;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_s1   <= RST_VAL;
      r_s2   <= RST_VAL;
      r_s3   <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_s1   <= i_d;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= r_s2 & ~r_s3;
      r_fall <= ~r_s2 & r_s3;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/tmc_spi_responder.sv
// SPI mode-3 responder for the 40-bit driver datagram: small register file,
// status byte plus previous read data returned on MISO.
module tmc_spi_responder
  import tmc_spi_pkg::*;
#(
  parameter int unsigned REG_COUNT    = 16,
  parameter logic [7:0]  STATUS_RESET = 8'h00
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 sck_in,
  input  logic                 cs_n_in,
  input  logic                 sdi_in,
  output logic                 sdo_out,
  input  logic [7:0]           status_in,
  output logic                 wr_stb_out,
  output logic [ADDR_BITS-1:0] wr_addr_out,
  output logic [DATA_BITS-1:0] wr_data_out,
  output logic                 frame_err_out
);

  localparam int unsigned IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  logic w_sck_unused_level, w_sck_rise, w_sck_fall;
  logic w_cs_level, w_cs_rise, w_cs_fall;
  logic w_sdi, w_sdi_unused_rise, w_sdi_unused_fall;

  // cs_n resets low so a frame in flight at reset release is held off in WAIT_IDLE
  sync_edge #(.RST_VAL(1'b1)) u_sck (
    .clk_in(clk_in), .reset_in(reset_in), .i_d(sck_in),
    .o_level(w_sck_unused_level), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );
  sync_edge #(.RST_VAL(1'b0)) u_cs (
    .clk_in(clk_in), .reset_in(reset_in), .i_d(cs_n_in),
    .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );
  sync_edge #(.RST_VAL(1'b0)) u_sdi (
    .clk_in(clk_in), .reset_in(reset_in), .i_d(sdi_in),
    .o_level(w_sdi), .o_rise(w_sdi_unused_rise), .o_fall(w_sdi_unused_fall)
  );

  state_e                  r_state, w_state_nxt;
  logic [FRAME_BITS-1:0]   r_tx, w_tx_nxt;
  logic [FRAME_BITS-1:0]   r_rx, w_rx_nxt;
  logic [CNT_BITS-1:0]     r_cnt, w_cnt_nxt;
  logic [DATA_BITS-1:0]    r_rd_latch, w_rd_latch_nxt;
  logic [7:0]              r_status;
  logic                    r_sdo, w_sdo_nxt;
  logic                    r_wr_stb, w_wr_stb_nxt;
  logic [ADDR_BITS-1:0]    r_wr_addr, w_wr_addr_nxt;
  logic [DATA_BITS-1:0]    r_wr_data, w_wr_data_nxt;
  logic                    r_frame_err, w_frame_err_nxt;
  logic                    w_we;
  logic [DATA_BITS-1:0]    r_regs [REG_COUNT];

  logic [ADDR_BITS-1:0]    w_addr;
  logic [DATA_BITS-1:0]    w_data;
  logic                    w_is_write, w_in_range, w_full;
  logic [IDX_W-1:0]        w_idx;
  logic [DATA_BITS-1:0]    w_rd_val;

  assign w_addr     = r_rx[WRITE_FLAG_BIT-1 -: ADDR_BITS];
  assign w_data     = r_rx[DATA_BITS-1:0];
  assign w_is_write = r_rx[WRITE_FLAG_BIT];
  assign w_in_range = 32'(w_addr) < REG_COUNT;
  assign w_idx      = w_addr[IDX_W-1:0];
  assign w_full     = (r_cnt == CNT_BITS'(FRAME_BITS));
  // Read-back sees a write made by the same frame
  assign w_rd_val   = !w_in_range ? '0 : (w_is_write ? w_data : r_regs[w_idx]);

  always_comb begin
    w_state_nxt     = r_state;
    w_tx_nxt        = r_tx;
    w_rx_nxt        = r_rx;
    w_cnt_nxt       = r_cnt;
    w_rd_latch_nxt  = r_rd_latch;
    w_wr_addr_nxt   = r_wr_addr;
    w_wr_data_nxt   = r_wr_data;
    w_wr_stb_nxt    = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_we            = 1'b0;
    case (r_state)
      WAIT_IDLE: if (w_cs_level) w_state_nxt = IDLE;
      IDLE: begin
        if (w_cs_fall) begin
          w_tx_nxt    = {r_status, r_rd_latch};
          w_cnt_nxt   = '0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // cs_n rising wins over a coincident SCK edge
        if (w_cs_rise) begin
          w_state_nxt = COMMIT;
          if (w_full) begin
            if (w_is_write) begin
              w_wr_stb_nxt  = 1'b1;
              w_wr_addr_nxt = w_addr;
              w_wr_data_nxt = w_data;
              w_we          = w_in_range;
            end
            w_rd_latch_nxt = w_rd_val;
          end else begin
            w_frame_err_nxt = 1'b1;
          end
        end else if (w_sck_rise) begin
          w_rx_nxt  = {r_rx[FRAME_BITS-2:0], w_sdi};
          w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + CNT_BITS'(1);
        end else if (w_sck_fall) begin
          w_tx_nxt = {r_tx[FRAME_BITS-2:0], 1'b0};
        end
      end
      COMMIT: begin
        w_state_nxt = IDLE;
        if (w_cs_fall) begin
          w_tx_nxt    = {r_status, r_rd_latch};
          w_cnt_nxt   = '0;
          w_state_nxt = SHIFT;
        end
      end
      default: w_state_nxt = WAIT_IDLE;
    endcase
  end

  assign w_sdo_nxt = (w_state_nxt == SHIFT) && w_tx_nxt[FRAME_BITS-1];

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state     <= WAIT_IDLE;
      r_tx        <= '0;
      r_rx        <= '0;
      r_cnt       <= '0;
      r_rd_latch  <= '0;
      r_status    <= STATUS_RESET;
      r_sdo       <= 1'b0;
      r_wr_stb    <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tx        <= w_tx_nxt;
      r_rx        <= w_rx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rd_latch  <= w_rd_latch_nxt;
      r_status    <= status_in;
      r_sdo       <= w_sdo_nxt;
      r_wr_stb    <= w_wr_stb_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      for (int i = 0; i < int'(REG_COUNT); i++) r_regs[i] <= '0;
    end else if (w_we) begin
      r_regs[w_idx] <= w_data;
    end
  end

  assign sdo_out       = r_sdo;
  assign wr_stb_out    = r_wr_stb;
  assign wr_addr_out   = r_wr_addr;
  assign wr_data_out   = r_wr_data;
  assign frame_err_out = r_frame_err;

endmodule
